exec_perf_counter: RTL and testbench
====================================

EXEC_PERF_COUNTER -- requirements
Module: exec_perf_counter

Interface
REQ-001 Parameter NUM_CH, default 10, number of monitored execution channels (0 SALU, 1-4 SIMD, 5-8 SIMF, 9 LSU).
REQ-002 Parameter CNT_W, default 32, width of every event/sum counter.
REQ-003 Parameter OCC_W, default 6, width of per-channel in-flight occupancy.
REQ-004 Parameter WINDOW, default 100, sampling window length in enabled cycles.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  counting enable; window advances only when 1.
REQ-008 clr  input  1  synchronous clear of live counters.
REQ-009 ch_start  input  NUM_CH  per-channel issue pulse (one instruction started).
REQ-010 ch_done  input  NUM_CH  per-channel completion pulse (one instruction written back).
REQ-011 rd_req  input  1  readout request.
REQ-012 rd_ch  input  clog2(NUM_CH)  channel index to read.
REQ-013 rd_field  input  2  0 start count, 1 done count, 2 occupancy sum, 3 occupancy max.
REQ-014 rd_ack  output  1  one-cycle readout valid pulse.
REQ-015 rd_data  output  CNT_W  readout value.
REQ-016 snap_valid  output  1  one-cycle pulse: new window snapshot available.
REQ-017 ovf  output  NUM_CH  sticky per-channel saturation/error flag.

Function
REQ-018 Occupancy occ[c] SHALL update every cycle regardless of en: +1 on start only, -1 on done only, unchanged on both or neither.
REQ-019 Done with occ[c]=0 and no start SHALL leave occ at 0 and set ovf[c]; start with occ[c]=2^OCC_W-1 and no done SHALL hold occ and set ovf[c].
REQ-020 With en=1, live start_cnt[c] and done_cnt[c] SHALL increment by 1 per pulse; occ_sum[c] SHALL add the pre-update occ[c] each cycle; occ_max[c] SHALL take max(occ_max, post-update occ).
REQ-021 Each live counter SHALL saturate at all-ones and set ovf[c] on any saturation attempt.
REQ-022 Window counter wcnt SHALL count enabled cycles 0..WINDOW-1; with en=1 and wcnt=WINDOW-1 the edge SHALL copy all live values (including that cycle's events) into shadow registers, reset start_cnt/done_cnt/occ_sum to 0, load occ_max with post-update occ, set wcnt to 0.
REQ-023 snap_valid SHALL be 1 in exactly the cycle following the snapshot edge, else 0.
REQ-024 rd_req=1 at edge N SHALL produce rd_ack=1 and rd_data=shadow[rd_ch][rd_field] (value held before edge N) in cycle N+1; rd_ch>=NUM_CH SHALL return 0 with rd_ack=1.
REQ-025 Back-to-back rd_req SHALL be accepted every cycle; rd_data SHALL be 0 when rd_ack=0.
REQ-026 clr=1 SHALL zero live counters, wcnt and ovf, SHALL NOT alter occ or shadow registers, SHALL take priority over en and suppress any snapshot that cycle.
REQ-027 occ_max reset by clr SHALL load current post-update occ.

Reset
REQ-028 rst=0 SHALL immediately zero occ, all live and shadow counters, wcnt, ovf, rd_ack, rd_data, snap_valid, independent of clk.
REQ-029 Reset asserted mid-window SHALL discard partial window; counting restarts at wcnt=0 after release.

Verification
REQ-030 WINDOW=4, en=1, ch_start[1] pulses cycles 0,1, ch_done[1] cycle 3 -> snap_valid after cycle 3; read ch1 fields -> starts 2, done 1, occ_sum 0+1+2+2=5, max 2.
REQ-031 Same-cycle start+done on ch0 with occ=3 -> occ stays 3, both counters +1, ovf[0]=0.
REQ-032 Done on ch9 with occ=0 -> occ 0, ovf[9]=1, done_cnt still +1; clr -> ovf[9]=0.
REQ-033 CNT_W=4, 20 starts on ch2 in one window -> shadow start count 15, ovf[2]=1.
REQ-034 rd_req with rd_ch=12 -> rd_ack=1, rd_data=0 next cycle; rd_req on snapshot edge -> old shadow value returned.
REQ-035 rst=0 asserted asynchronously between edges with wcnt=2 -> all outputs 0 immediately; after release, first snap_valid after WINDOW enabled cycles.

Source files
------------

// File: rtl/exec_perf_counter.sv
// Per-channel execution performance counters: live occupancy tracking, windowed
// event/occupancy statistics with shadow snapshots, and a registered readout port.
module exec_perf_counter #(
   parameter int NUM_CH = 10,
   parameter int CNT_W  = 32,
   parameter int OCC_W  = 6,
   parameter int WINDOW = 100
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            en,
   input  logic                                            clr,
   input  logic [NUM_CH-1:0]                               ch_start,
   input  logic [NUM_CH-1:0]                               ch_done,
   input  logic                                            rd_req,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  rd_ch,
   input  logic [1:0]                                      rd_field,
   output logic                                            rd_ack,
   output logic [CNT_W-1:0]                                rd_data,
   output logic                                            snap_valid,
   output logic [NUM_CH-1:0]                               ovf
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int WC_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int EXT_W = (CNT_W > OCC_W) ? CNT_W : OCC_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [OCC_W-1:0] OCC_MAX = {OCC_W{1'b1}};
   localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
   localparam logic [CH_W:0]    CH_LIM  = (CH_W + 1)'(NUM_CH);

   // Saturating add; MSB of the result flags a saturation attempt.
   function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[CNT_W]) return {1'b1, CNT_MAX};
      return s;
   endfunction

   // Occupancy widened (or clamped) to counter width.
   function automatic logic [CNT_W-1:0] occ_to_cnt(input logic [OCC_W-1:0] v);
      logic [EXT_W-1:0] x;
      x = EXT_W'(v);
      if (x > EXT_W'(CNT_MAX)) return CNT_MAX;
      return x[CNT_W-1:0];
   endfunction

   logic [OCC_W-1:0] occ       [NUM_CH];
   logic [OCC_W-1:0] occ_nxt   [NUM_CH];
   logic [CNT_W-1:0] start_cnt [NUM_CH];
   logic [CNT_W-1:0] done_cnt  [NUM_CH];
   logic [CNT_W-1:0] occ_sum   [NUM_CH];
   logic [OCC_W-1:0] occ_max   [NUM_CH];
   logic [CNT_W-1:0] start_nxt [NUM_CH];
   logic [CNT_W-1:0] done_nxt  [NUM_CH];
   logic [CNT_W-1:0] sum_nxt   [NUM_CH];
   logic [OCC_W-1:0] max_nxt   [NUM_CH];
   logic [CNT_W-1:0] sh_start  [NUM_CH];
   logic [CNT_W-1:0] sh_done   [NUM_CH];
   logic [CNT_W-1:0] sh_sum    [NUM_CH];
   logic [OCC_W-1:0] sh_max    [NUM_CH];
   logic [NUM_CH-1:0] occ_err, sat_s, sat_d, sat_u, cnt_sat;
   logic [WC_W-1:0]  wcnt;
   logic             snap;
   logic [CNT_W-1:0] rd_mux;

   assign snap = en && !clr && (wcnt == WC_LAST);

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         occ_nxt[c] = occ[c];
         occ_err[c] = 1'b0;
         if (ch_start[c] && !ch_done[c]) begin
            if (occ[c] == OCC_MAX) occ_err[c] = 1'b1;
            else                   occ_nxt[c] = occ[c] + 1'b1;
         end else if (ch_done[c] && !ch_start[c]) begin
            if (occ[c] == '0) occ_err[c] = 1'b1;
            else              occ_nxt[c] = occ[c] - 1'b1;
         end
         {sat_s[c], start_nxt[c]} = sat_add(start_cnt[c], CNT_W'(ch_start[c]));
         {sat_d[c], done_nxt[c]}  = sat_add(done_cnt[c], CNT_W'(ch_done[c]));
         {sat_u[c], sum_nxt[c]}   = sat_add(occ_sum[c], occ_to_cnt(occ[c]));
         cnt_sat[c] = sat_s[c] | sat_d[c] | sat_u[c];
         max_nxt[c] = (occ_nxt[c] > occ_max[c]) ? occ_nxt[c] : occ_max[c];
      end
   end

   always_comb begin
      rd_mux = '0;
      if ({1'b0, rd_ch} < CH_LIM) begin
         case (rd_field)
            2'd0:    rd_mux = sh_start[rd_ch];
            2'd1:    rd_mux = sh_done[rd_ch];
            2'd2:    rd_mux = sh_sum[rd_ch];
            default: rd_mux = occ_to_cnt(sh_max[rd_ch]);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt       <= '0;
         ovf        <= '0;
         snap_valid <= 1'b0;
         rd_ack     <= 1'b0;
         rd_data    <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            occ[c]       <= '0;
            start_cnt[c] <= '0;
            done_cnt[c]  <= '0;
            occ_sum[c]   <= '0;
            occ_max[c]   <= '0;
            sh_start[c]  <= '0;
            sh_done[c]   <= '0;
            sh_sum[c]    <= '0;
            sh_max[c]    <= '0;
         end
      end else begin
         // stage p1: readout and snapshot strobe registered
         snap_valid <= snap;
         rd_ack     <= rd_req;
         rd_data    <= rd_req ? rd_mux : '0;
         for (int c = 0; c < NUM_CH; c++) occ[c] <= occ_nxt[c];
         if (clr) begin
            wcnt <= '0;
            ovf  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
               start_cnt[c] <= '0;
               done_cnt[c]  <= '0;
               occ_sum[c]   <= '0;
               occ_max[c]   <= occ_nxt[c];
            end
         end else begin
            ovf <= ovf | occ_err | (en ? cnt_sat : '0);
            if (en) begin
               wcnt <= snap ? '0 : wcnt + 1'b1;
               for (int c = 0; c < NUM_CH; c++) begin
                  if (snap) begin
                     sh_start[c]  <= start_nxt[c];
                     sh_done[c]   <= done_nxt[c];
                     sh_sum[c]    <= sum_nxt[c];
                     sh_max[c]    <= max_nxt[c];
                     start_cnt[c] <= '0;
                     done_cnt[c]  <= '0;
                     occ_sum[c]   <= '0;
                     occ_max[c]   <= occ_nxt[c];
                  end else begin
                     start_cnt[c] <= start_nxt[c];
                     done_cnt[c]  <= done_nxt[c];
                     occ_sum[c]   <= sum_nxt[c];
                     occ_max[c]   <= max_nxt[c];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_perf_counter.sv
// Directed bench for exec_perf_counter: a WINDOW=4 instance driven from a vector
// table plus hand sequences, and a CNT_W=4 instance for counter saturation.
module tb_exec_perf_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, clr = 1'b0, rd_req = 1'b0;
   logic [9:0]  ch_start = '0, ch_done = '0;
   logic [3:0]  rd_ch = '0;
   logic [1:0]  rd_field = '0;
   logic        rd_ack, snap_valid;
   logic [31:0] rd_data;
   logic [9:0]  ovf;

   logic        en_b = 1'b0, clr_b = 1'b0, rd_req_b = 1'b0;
   logic [9:0]  start_b = '0, done_b = '0;
   logic [3:0]  rd_ch_b = '0;
   logic [1:0]  rd_field_b = '0;
   logic        rd_ack_b, snap_b;
   logic [3:0]  rd_data_b;
   logic [9:0]  ovf_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exec_perf_counter #(.NUM_CH(10), .CNT_W(32), .OCC_W(6), .WINDOW(4)) u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ch_start(ch_start), .ch_done(ch_done),
      .rd_req(rd_req), .rd_ch(rd_ch), .rd_field(rd_field), .rd_ack(rd_ack),
      .rd_data(rd_data), .snap_valid(snap_valid), .ovf(ovf));

   exec_perf_counter #(.NUM_CH(10), .CNT_W(4), .OCC_W(6), .WINDOW(24)) u_small (
      .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .ch_start(start_b), .ch_done(done_b),
      .rd_req(rd_req_b), .rd_ch(rd_ch_b), .rd_field(rd_field_b), .rd_ack(rd_ack_b),
      .rd_data(rd_data_b), .snap_valid(snap_b), .ovf(ovf_b));

   typedef struct {
      logic        en;
      logic        clr;
      logic [9:0]  st;
      logic [9:0]  dn;
      logic        rd;
      logic [3:0]  ch;
      logic [1:0]  fld;
      logic        ack;
      logic [31:0] data;
      logic        snap;
      logic [9:0]  ovf;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic e, input logic c, input logic [9:0] s,
                               input logic [9:0] d, input logic r, input logic [3:0] ch,
                               input logic [1:0] f, input logic a, input logic [31:0] dat,
                               input logic sv, input logic [9:0] o);
      vec_t v;
      v.en = e; v.clr = c; v.st = s; v.dn = d; v.rd = r; v.ch = ch; v.fld = f;
      v.ack = a; v.data = dat; v.snap = sv; v.ovf = o;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;

      // Window of 4 on ch1, then readout across the next snapshot edge
      add(1,0,10'h002,0,0,0,0, 0,0,0,0);
      add(1,0,10'h002,0,0,0,0, 0,0,0,0);
      add(1,0,0,0,0,0,0,       0,0,0,0);
      add(1,0,0,10'h002,0,0,0, 0,0,1,0);
      add(1,0,0,0,1,1,0,       1,2,0,0);
      add(1,0,0,0,1,1,1,       1,1,0,0);
      add(1,0,0,0,1,1,2,       1,5,0,0);
      add(1,0,0,0,1,1,3,       1,2,1,0);
      add(1,0,0,0,1,1,2,       1,4,0,0);
      // ch0 to occupancy 3, then simultaneous start+done
      add(1,0,10'h001,0,0,0,0, 0,0,0,0);
      add(1,0,10'h001,0,0,0,0, 0,0,0,0);
      add(1,0,10'h001,0,0,0,0, 0,0,1,0);
      add(1,0,10'h001,10'h001,0,0,0, 0,0,0,0);
      add(1,0,0,0,0,0,0,       0,0,0,0);
      add(1,0,0,0,0,0,0,       0,0,0,0);
      add(1,0,0,0,0,0,0,       0,0,1,0);
      add(1,0,0,0,1,0,0,       1,1,0,0);
      add(1,0,0,0,1,0,1,       1,1,0,0);
      add(1,0,0,0,1,0,3,       1,3,0,0);
      add(1,0,0,0,1,0,2,       1,12,1,0);
      // ch9 underflow, clear, out-of-range read, clear suppresses snapshot
      add(1,0,0,10'h200,0,0,0, 0,0,0,10'h200);
      add(1,0,0,0,0,0,0,       0,0,0,10'h200);
      add(1,0,0,0,0,0,0,       0,0,0,10'h200);
      add(1,0,0,0,0,0,0,       0,0,1,10'h200);
      add(1,0,0,0,1,9,1,       1,1,0,10'h200);
      add(1,1,0,0,0,0,0,       0,0,0,0);
      add(1,0,0,0,1,9,1,       1,1,0,0);
      add(1,0,0,0,1,12,0,      1,0,0,0);
      add(1,0,0,0,0,0,0,       0,0,0,0);
      add(1,1,0,0,0,0,0,       0,0,0,0);
      add(1,0,0,0,1,9,1,       1,1,0,0);
      // disabled cycles do not advance the window
      add(0,0,0,0,0,0,0,       0,0,0,0);
      add(0,0,0,0,0,0,0,       0,0,0,0);
      add(1,0,0,0,0,0,0,       0,0,0,0);
      add(1,0,0,0,0,0,0,       0,0,0,0);
      add(1,0,0,0,0,0,0,       0,0,1,0);
      add(1,0,0,0,1,9,1,       1,0,0,0);

      #1 rst = 1'b0;
      #1;
      chk("rst_ack", {31'd0, rd_ack}, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_snap", {31'd0, snap_valid}, 0);
      chk("rst_ovf", {22'd0, ovf}, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      for (int i = 0; i < vq.size(); i++) begin
         en = vq[i].en; clr = vq[i].clr; ch_start = vq[i].st; ch_done = vq[i].dn;
         rd_req = vq[i].rd; rd_ch = vq[i].ch; rd_field = vq[i].fld;
         tick();
         chk($sformatf("v%0d_ack", i), {31'd0, rd_ack}, {31'd0, vq[i].ack});
         chk($sformatf("v%0d_data", i), rd_data, vq[i].data);
         chk($sformatf("v%0d_snap", i), {31'd0, snap_valid}, {31'd0, vq[i].snap});
         chk($sformatf("v%0d_ovf", i), {22'd0, ovf}, {22'd0, vq[i].ovf});
      end

      // Asynchronous reset mid-window (wcnt=2) with live outputs
      en = 1'b1; clr = 1'b0; ch_start = '0; ch_done = 10'h200;
      rd_req = 1'b1; rd_ch = 4'd1; rd_field = 2'd0;
      tick();
      chk("pre_rst_ack", {31'd0, rd_ack}, 1);
      chk("pre_rst_ovf", {22'd0, ovf}, {22'd0, 10'h200});
      ch_done = '0; rd_req = 1'b0;
      #3 rst = 1'b0;
      #1;
      chk("async_ack", {31'd0, rd_ack}, 0);
      chk("async_data", rd_data, 0);
      chk("async_snap", {31'd0, snap_valid}, 0);
      chk("async_ovf", {22'd0, ovf}, 0);
      #2 rst = 1'b1;
      k = 13;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (snap_valid) begin
            k = n;
            break;
         end
      end
      chk("rst_window_cycles", k, 4);
      rd_req = 1'b1; rd_ch = 4'd0; rd_field = 2'd2;
      tick();
      chk("post_rst_ack", {31'd0, rd_ack}, 1);
      chk("post_rst_sum", rd_data, 0);
      rd_req = 1'b0; en = 1'b0;

      // 20 starts on ch2 into 4-bit counters
      en_b = 1'b1;
      for (int n = 0; n < 20; n++) begin
         start_b = 10'h004;
         tick();
      end
      start_b = '0;
      for (int n = 0; n < 4; n++) tick();
      chk("sat_snap", {31'd0, snap_b}, 1);
      chk("sat_ovf", {22'd0, ovf_b}, {22'd0, 10'h004});
      rd_req_b = 1'b1; rd_ch_b = 4'd2; rd_field_b = 2'd0;
      tick();
      chk("sat_start", {28'd0, rd_data_b}, 15);
      rd_field_b = 2'd3;
      tick();
      chk("sat_max", {28'd0, rd_data_b}, 15);
      rd_field_b = 2'd1;
      tick();
      chk("sat_done", {28'd0, rd_data_b}, 0);
      rd_req_b = 1'b0;
      tick();
      chk("idle_data_b", {28'd0, rd_data_b}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
